// File: rtl/trng_ctrl_if.sv
// Bus-side word handshake between trng_ctrl and its consumer.
interface trng_ctrl_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] rdata;
   logic             rvalid;
   logic             rready;

   modport master (
      output rdata,
      output rvalid,
      input  rready
   );

   modport slave (
      input  rdata,
      input  rvalid,
      output rready
   );
endinterface

// File: rtl/trng_ctrl.sv
// Ring-oscillator TRNG controller: gates the macro, waits out warm-up, samples
// at a fixed divided rate, optionally von Neumann debiases, packs bits into
// WIDTH-bit words and hands each word over a valid/ready handshake.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | macro off, waiting for enable
// WARMUP  | macro on, counting WARMUP_CYCLES before the first sample
// COLLECT | macro on, sampling every SAMPLE_DIV cycles and packing bits
// HOLD    | macro on, word presented on rdata/rvalid, collection stalled
module trng_ctrl #(
   parameter int WIDTH         = 32,
   parameter int WARMUP_CYCLES = 64,
   parameter int SAMPLE_DIV    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       debias_en,
   output logic       trng_en,
   input  logic       trng_out,
   output logic       busy,
   trng_ctrl_if.master bus
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WARMUP  = 2'd1;
   localparam logic [1:0] ST_COLLECT = 2'd2;
   localparam logic [1:0] ST_HOLD    = 2'd3;

   localparam int WU_W  = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int BIT_W = $clog2(WIDTH);

   localparam logic [WU_W-1:0]  WU_LAST  = WU_W'(WARMUP_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [WU_W-1:0]  warm_cnt;
   logic [DIV_W-1:0] div_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic             debias_q;
   logic             pair_have;
   logic             pair_a;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] rdata_q;
   logic             rvalid_q;

   logic strobe;
   logic warm_done;
   logic emit;
   logic emit_bit;
   logic word_done;
   logic accept;
   logic finish_word;

   assign strobe      = (state == ST_COLLECT) && (div_cnt == DIV_LAST);
   assign warm_done   = (state == ST_WARMUP) && (warm_cnt == WU_LAST);
   assign word_done   = emit && (bit_cnt == BIT_LAST);
   assign accept      = rvalid_q && bus.rready;
   assign finish_word = (state == ST_COLLECT) && (state_nxt == ST_HOLD);

   assign trng_en    = (state != ST_IDLE);
   assign busy       = (state != ST_IDLE);
   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;

   // Decide whether this strobe produces an output bit. In debias mode the
   // second sample of an unequal pair emits the first sample's value.
   always_comb begin
      emit     = 1'b0;
      emit_bit = trng_out;
      if (strobe) begin
         if (!debias_q) begin
            emit = 1'b1;
         end else if (pair_have && (pair_a != trng_out)) begin
            emit     = 1'b1;
            emit_bit = pair_a;
         end
      end
   end

   // Next-state logic; dropping enable aborts warm-up/collection, but a held
   // word must still be consumed before going idle.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (enable) state_nxt = ST_WARMUP;
         end
         ST_WARMUP: begin
            if (!enable)        state_nxt = ST_IDLE;
            else if (warm_done) state_nxt = ST_COLLECT;
         end
         ST_COLLECT: begin
            if (!enable)        state_nxt = ST_IDLE;
            else if (word_done) state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (accept) state_nxt = enable ? ST_COLLECT : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Warm-up counter: held at zero outside WARMUP so every run starts fresh.
   always_ff @(posedge clk) begin
      if (reset)                  warm_cnt <= '0;
      else if (state == ST_WARMUP) warm_cnt <= warm_cnt + 1'b1;
      else                        warm_cnt <= '0;
   end

   // Debias mode is frozen for the whole run at the IDLE->WARMUP transition.
   always_ff @(posedge clk) begin
      if (reset)                             debias_q <= 1'b0;
      else if ((state == ST_IDLE) && enable) debias_q <= debias_en;
   end

   // Sample divider: runs only in COLLECT, zero everywhere else.
   always_ff @(posedge clk) begin
      if (reset)                    div_cnt <= '0;
      else if (state != ST_COLLECT) div_cnt <= '0;
      else if (strobe)              div_cnt <= '0;
      else                          div_cnt <= div_cnt + 1'b1;
   end

   // Pair register for debiasing; cleared whenever not collecting so a new
   // COLLECT entry never pairs with a stale sample.
   always_ff @(posedge clk) begin
      if (reset || (state != ST_COLLECT)) begin
         pair_have <= 1'b0;
         pair_a    <= 1'b0;
      end else if (strobe && debias_q) begin
         pair_have <= !pair_have;
         if (!pair_have) pair_a <= trng_out;
      end
   end

   // Bit packing: first emitted bit ends up in the MSB of the finished word.
   always_ff @(posedge clk) begin
      if (reset || (state != ST_COLLECT)) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (emit) begin
         shreg   <= {shreg[WIDTH-2:0], emit_bit};
         bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end
   end

   // Output word and valid flag: set together on word completion, valid
   // cleared only by an accepted transfer or reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else if (finish_word) begin
         rdata_q  <= {shreg[WIDTH-2:0], emit_bit};
         rvalid_q <= 1'b1;
      end else if (accept) begin
         rvalid_q <= 1'b0;
      end
   end

endmodule
